pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, registered in_ready and synchronous flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall and bubble counters.
module pipe_stage_skid #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 4,
    parameter logic [DATA_W-1:0]  DATA_RST = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic accept;
    logic deliver;
    logic load_main_in;
    logic load_skid_in;
    logic move_skid;
    logic clr_main;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    // State register; in_ready is registered alongside so it never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
        end
    end

    always_comb begin
        state_nxt    = state;
        load_main_in = 1'b0;
        load_skid_in = 1'b0;
        move_skid    = 1'b0;
        clr_main     = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt    = TWO;
                        load_skid_in = 1'b1;
                    end else if (deliver) begin
                        state_nxt = EMPTY;
                        clr_main  = 1'b1;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        state_nxt = ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state != EMPTY);
        out_data  = main_data;
        out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_data <= DATA_RST;
            main_ctrl <= '0;
            skid_data <= DATA_RST;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_data <= DATA_RST;
            main_ctrl <= '0;
            skid_data <= DATA_RST;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (move_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end else if (clr_main) begin
                main_ctrl <= '0;
            end
            if (load_skid_in) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end else if (move_skid) begin
                skid_ctrl <= '0;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (!out_valid && (perf_bubble_cnt != 32'hFFFF_FFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a negedge monitor that checks
// every delivered entry against an expected queue; perf checks when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_ctrl;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    logic [35:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    pipe_stage_skid dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] d, input logic [3:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    // scoreboard monitor: samples at negedge, where inputs and outputs are settled
    logic [35:0] got;
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
        end else begin
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            if (!out_valid) chk("ctrl_bubble", 64'(out_ctrl), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0h, expected no entry", {out_ctrl, out_data});
                end else begin
                    got = exp_q.pop_front();
                    chk("out_entry", 64'({out_ctrl, out_data}), 64'(got));
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
        end
    end

    logic [31:0] seq_d[4];
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        offer(1'b0, 32'h0, 4'h0);
        seq_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        resetn = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        // 4 bubble edges (3 idle + accept edge), then 3 stall edges
        step(); step(); step();
        offer(1'b1, 32'hE1, 4'h3);
        step();
        offer(1'b0, 32'h0, 4'h0);
        step(); step(); step();
        chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
        chk("perf_bubble", 64'(perf_bubble_cnt), 64'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_stall_flush", 64'(perf_stall_cnt), 64'd4);
        chk("perf_bubble_flush", 64'(perf_bubble_cnt), 64'd4);
        chk("perf_flush_empty", 64'(out_valid), 64'd0);
`endif

        // streaming, out_ready high: each word visible one cycle after offer
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, seq_d[i], 4'(i + 1));
            step();
            chk("stream_data", 64'(out_data), 64'(seq_d[i]));
            chk("stream_occ", 64'(occupancy), 64'd1);
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        offer(1'b0, 32'h0, 4'h0);
        step();
        chk("stream_drain", 64'(occupancy), 64'd0);

        // fill with backpressure, A3 must be ignored
        out_ready = 1'b0;
        offer(1'b1, 32'hA1, 4'h5);
        step();
        chk("fill1_occ", 64'(occupancy), 64'd1);
        offer(1'b1, 32'hA2, 4'h6);
        step();
        chk("fill2_occ", 64'(occupancy), 64'd2);
        chk("fill2_ready", 64'(in_ready), 64'd0);
        offer(1'b1, 32'hA3, 4'h7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_data", 64'(out_data), 64'hA1);
            chk("hold_occ", 64'(occupancy), 64'd2);
        end
        offer(1'b0, 32'hxxxx_xxxx, 4'hx);
        out_ready = 1'b1;
        #1;
        chk("drain_a1", 64'(out_data), 64'hA1);
        step();
        chk("drain_a2", 64'(out_data), 64'hA2);
        chk("drain_a2_ready", 64'(in_ready), 64'd1);
        step();
        chk("drain_empty", 64'(out_valid), 64'd0);
        offer(1'b0, 32'h0, 4'h0);

        // flush with two entries, ctrl all ones
        out_ready = 1'b0;
        offer(1'b1, 32'hB1, 4'hF);
        step();
        offer(1'b1, 32'hB2, 4'hF);
        step();
        offer(1'b1, 32'hB3, 4'hF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 4'h0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_data", 64'(out_data), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);

        // flush in ONE with a delivery and an accepted-looking offer: C2 never emerges
        offer(1'b1, 32'hC1, 4'h9);
        step();
        offer(1'b1, 32'hC2, 4'hA);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 4'h0);
        chk("flush1_occ", 64'(occupancy), 64'd0);
        step(); step();
        chk("flush1_quiet", 64'(out_valid), 64'd0);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            offer(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        offer(1'b0, 32'h0, 4'h0);
        out_ready = 1'b1;
        step(); step(); step();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        // asynchronous reset mid-cycle with two entries held
        out_ready = 1'b0;
        offer(1'b1, 32'hD0, 4'hF);
        step();
        offer(1'b1, 32'hD1, 4'hF);
        step();
        offer(1'b0, 32'h0, 4'h0);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        step();
        resetn = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'hD5, 4'h2);
        step();
        offer(1'b0, 32'h0, 4'h0);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'hD5);
        chk("post_rst_ctrl", 64'(out_ctrl), 64'h2);
        step(); step();
        chk("final_empty", 64'(exp_q.size()), 64'd0);
        chk("final_occ", 64'(occupancy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
